// File: rtl/cam_stream_pkg.sv
// Shared definitions for the synthetic camera stream generator.
// Latency: n/a (constants, encodings and a colour lookup only).
// Backpressure: n/a.
// Contents: FSM state codes, pattern_sel codes, colour-bar RGB565 table.
package cam_stream_pkg;

    // Coordinate width handed to the pattern generator; wide enough for
    // any practical WIDTH/HEIGHT and for the x[7:*] slices the gradient uses.
    localparam int COORD_W = 12;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBACK  = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_VFRONT = 3'd4;

    // pattern_sel codes
    localparam logic [1:0] SEL_BARS  = 2'b00;
    localparam logic [1:0] SEL_GRAD  = 2'b01;
    localparam logic [1:0] SEL_CHECK = 2'b10;
    localparam logic [1:0] SEL_SOLID = 2'b11;

    // Colour-bar RGB565 values, left to right
    localparam logic [15:0] BAR0 = 16'hFFFF;
    localparam logic [15:0] BAR1 = 16'hFFE0;
    localparam logic [15:0] BAR2 = 16'h07FF;
    localparam logic [15:0] BAR3 = 16'h07E0;
    localparam logic [15:0] BAR4 = 16'hF81F;
    localparam logic [15:0] BAR5 = 16'hF800;
    localparam logic [15:0] BAR6 = 16'h001F;
    localparam logic [15:0] BAR7 = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR0;
            3'd1:    c = BAR1;
            3'd2:    c = BAR2;
            3'd3:    c = BAR3;
            3'd4:    c = BAR4;
            3'd5:    c = BAR5;
            3'd6:    c = BAR6;
            default: c = BAR7;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cam_stream_if.sv
// Camera-side bundle: run controls in, OV7670-style sync/data pins out.
// Latency: n/a (wires only).
// Backpressure: none; the stream is free-running like a real sensor.
// master = generator (drives vsync/href/px_data/frame_done/busy),
// slave  = controller/receiver (drives enable/pattern_sel).
interface cam_stream_if;
    logic       enable;
    logic [1:0] pattern_sel;
    logic       vsync;
    logic       href;
    logic [7:0] px_data;
    logic       frame_done;
    logic       busy;

    modport master (
        input  enable, pattern_sel,
        output vsync, href, px_data, frame_done, busy
    );

    modport slave (
        output enable, pattern_sel,
        input  vsync, href, px_data, frame_done, busy
    );
endinterface

// File: rtl/cam_stream_pattern.sv
// Test-pattern source: maps pixel coordinate (x, y) and pattern select to RGB565.
// Latency: combinational.
// Backpressure: none.
// Ports: x_i/y_i pixel coordinate, sel_i pattern code, rgb_o 16-bit RGB565.
module cam_stream_pattern
    import cam_stream_pkg::*;
#(
    parameter int WIDTH = 160
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [1:0]         sel_i,
    output logic [15:0]        rgb_o
);
    // Guard tiny widths so the divider never sees zero.
    localparam int BAR_W = (WIDTH / 8 > 0) ? WIDTH / 8 : 1;

    logic [COORD_W-1:0] bar;
    logic               unused_y;

    assign bar      = x_i / COORD_W'(BAR_W);
    // Only a few y bits feed the patterns.
    assign unused_y = ^{y_i[COORD_W-1:7], y_i[1:0]};

    always_comb begin
        rgb_o = 16'h0000;
        case (sel_i)
            // Widths not divisible by 8 leave a remainder; it joins the last bar.
            SEL_BARS:  rgb_o = bar_colour((bar > COORD_W'(7)) ? 3'd7 : bar[2:0]);
            SEL_GRAD:  rgb_o = {x_i[7:3], x_i[7:2], y_i[6:2]};
            SEL_CHECK: rgb_o = (x_i[3] ^ y_i[3]) ? 16'hFFFF : 16'h0000;
            SEL_SOLID: rgb_o = 16'hF800;
        endcase
    end

endmodule

// File: rtl/cam_stream_gen.sv
// Synthetic OV7670-style camera: vsync/href timing plus an RGB565 byte stream.
// Latency: all outputs registered; vsync rises on the edge after enable is seen in IDLE.
// Backpressure: none; frames run back-to-back while enable is high, never truncated.
// Ports: pclk pixel clock, rst async active-low reset, cam (master modport):
//   enable/pattern_sel in; vsync, href, px_data, frame_done, busy out.
// Option: define CAM_STREAM_SCROLL_EN to scroll the pattern one pixel per frame.
module cam_stream_gen
    import cam_stream_pkg::*;
#(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int HBLANK      = 16,
    parameter int VSYNC_LINES = 3,
    parameter int VBP         = 2,
    parameter int VFP         = 2
) (
    input  logic         pclk,
    input  logic         rst,
    cam_stream_if.master cam
);
    localparam int LINE_LEN    = 2 * WIDTH + HBLANK;
    localparam int FRAME_LINES = VSYNC_LINES + VBP + HEIGHT + VFP;
    localparam int COL_W       = $clog2(LINE_LEN);
    localparam int LINE_W      = $clog2(FRAME_LINES);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0]  HREF_END  = COL_W'(2 * WIDTH);
    localparam logic [LINE_W-1:0] VS_LAST   = LINE_W'(VSYNC_LINES - 1);
    localparam logic [LINE_W-1:0] VB_LAST   = LINE_W'(VSYNC_LINES + VBP - 1);
    localparam logic [LINE_W-1:0] ACT_FIRST = LINE_W'(VSYNC_LINES + VBP);
    localparam logic [LINE_W-1:0] ACT_LAST  = LINE_W'(VSYNC_LINES + VBP + HEIGHT - 1);
    localparam logic [LINE_W-1:0] FR_LAST   = LINE_W'(FRAME_LINES - 1);

    logic [2:0]         state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LINE_W-1:0]  line_q, line_d;   // line index within the whole frame
    logic [1:0]         sel_q, sel_d;
    logic               eol;

    logic               vsync_q, vsync_d;
    logic               href_q, href_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [7:0]         px_q, px_d;

    logic [COORD_W-1:0] x_raw, x_pat, y_act;
    logic [15:0]        rgb;

    assign eol = (col_q == COL_LAST);

    // Timing counters and FSM. Counters only advance outside IDLE.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (cam.enable) begin
                    state_d = ST_VSYNC;
                    col_d   = '0;
                    line_d  = '0;
                    sel_d   = cam.pattern_sel;
                end
            end
            default: begin
                col_d = eol ? '0 : col_q + COL_W'(1);
                if (eol) begin
                    line_d = line_q + LINE_W'(1);
                    case (state_q)
                        ST_VSYNC:  if (line_q == VS_LAST)  state_d = ST_VBACK;
                        ST_VBACK:  if (line_q == VB_LAST)  state_d = ST_ACTIVE;
                        ST_ACTIVE: if (line_q == ACT_LAST) state_d = ST_VFRONT;
                        default: begin
                            // End of frame: enable is only consulted here, so a
                            // frame in flight always runs to completion.
                            if (line_q == FR_LAST) begin
                                line_d = '0;
                                if (cam.enable) begin
                                    state_d = ST_VSYNC;
                                    sel_d   = cam.pattern_sel;
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    // Outputs are decoded from the next-state values and registered, so the
    // pins line up exactly with the counter values held after the same edge.
    assign x_raw = COORD_W'(col_d[COL_W-1:1]);
    assign y_act = COORD_W'(line_d - ACT_FIRST);

`ifdef CAM_STREAM_SCROLL_EN
    logic [7:0] fcnt_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            fcnt_q <= '0;
        end else if (done_d) begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end

    // Counter can exceed WIDTH, so a true modulo is needed, not one subtract.
    assign x_pat = COORD_W'((32'(x_raw) + 32'(fcnt_q)) % 32'(WIDTH));
`else
    assign x_pat = x_raw;
`endif

    cam_stream_pattern #(
        .WIDTH (WIDTH)
    ) u_pattern (
        .x_i   (x_pat),
        .y_i   (y_act),
        .sel_i (sel_q),
        .rgb_o (rgb)
    );

    always_comb begin
        vsync_d = (state_d == ST_VSYNC);
        href_d  = (state_d == ST_ACTIVE) && (col_d < HREF_END);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_VFRONT) && (line_d == FR_LAST) && (col_d == COL_LAST);
        // High byte on even columns, low byte on odd; quiet bus outside href.
        px_d    = href_d ? (col_d[0] ? rgb[7:0] : rgb[15:8]) : 8'h00;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            line_q  <= '0;
            sel_q   <= SEL_BARS;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            px_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            sel_q   <= sel_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            px_q    <= px_d;
        end
    end

    assign cam.vsync      = vsync_q;
    assign cam.href       = href_q;
    assign cam.px_data    = px_q;
    assign cam.frame_done = done_q;
    assign cam.busy       = busy_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Testbench for cam_stream_gen: per-cycle comparison against a frame-time model
// plus literal timing and pixel-byte expectations.
// WIDTH/line timing at full size; HEIGHT trimmed so many frames fit the run.
module tb_cam_stream_gen;

    localparam int W   = 160;
    localparam int H   = 10;
    localparam int HB  = 16;
    localparam int VS  = 3;
    localparam int VB  = 2;
    localparam int VF  = 2;
    localparam int LL  = 2 * W + HB;          // 336
    localparam int FL  = VS + VB + H + VF;    // 17 lines
    localparam int FC  = FL * LL;             // 5712 cycles

    localparam int S_VSYNC = 0;
    localparam int S_HREF  = 1;
    localparam int S_DONE  = 2;
    localparam int S_BUSY  = 3;

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    cam_stream_if cam();

    cam_stream_gen #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .HBLANK      (HB),
        .VSYNC_LINES (VS),
        .VBP         (VB),
        .VFP         (VF)
    ) dut (
        .pclk (pclk),
        .rst  (rst),
        .cam  (cam)
    );

    always #5 pclk = ~pclk;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;
    logic [7:0] line_buf [2*W];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h, t=%0t", nm, act, exp, $time);
    endtask

    function automatic int dut_vec();
        return {20'd0, cam.vsync, cam.href, cam.frame_done, cam.busy, cam.px_data};
    endfunction

    function automatic bit get_sig(input int which);
        case (which)
            S_VSYNC: return cam.vsync;
            S_HREF:  return cam.href;
            S_DONE:  return cam.frame_done;
            default: return cam.busy;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // A running frame is just a cycle index t; everything else is arithmetic on t.
    bit         m_run = 1'b0;
    int         m_t   = 0;
    int         m_fc  = 0;
    logic [1:0] m_sel = 2'b00;

    always @(posedge pclk or negedge rst) begin
        if (!rst) begin
            m_run = 1'b0;
            m_t   = 0;
            m_fc  = 0;
        end else if (!m_run) begin
            if (cam.enable) begin
                m_run = 1'b1;
                m_t   = 0;
                m_sel = cam.pattern_sel;
            end
        end else begin
            m_t++;
            if (m_t == FC) begin
                m_fc = (m_fc + 1) % 256;
                m_t  = 0;
                if (cam.enable) m_sel = cam.pattern_sel;
                else            m_run = 1'b0;
            end
        end
    end

    function automatic logic [15:0] ref_pix(input int x, input int y, input logic [1:0] s);
        case (s)
            2'b00: begin
                case (x / (W / 8))
                    0: return 16'hFFFF;
                    1: return 16'hFFE0;
                    2: return 16'h07FF;
                    3: return 16'h07E0;
                    4: return 16'hF81F;
                    5: return 16'hF800;
                    6: return 16'h001F;
                    default: return 16'h0000;
                endcase
            end
            2'b01:   return 16'((((x >> 3) & 31) << 11) | (((x >> 2) & 63) << 5) | ((y >> 2) & 31));
            2'b10:   return (((x >> 3) & 1) != ((y >> 3) & 1)) ? 16'hFFFF : 16'h0000;
            default: return 16'hF800;
        endcase
    endfunction

    function automatic int exp_vec();
        int line, col, x, y, sc;
        logic [15:0] rgb;
        int vs, hr, dn, by, px;
        vs = 0; hr = 0; dn = 0; by = 0; px = 0;
        sc = 0;
`ifdef CAM_STREAM_SCROLL_EN
        sc = m_fc;
`endif
        if (m_run) begin
            line = m_t / LL;
            col  = m_t % LL;
            by   = 1;
            if (line < VS) vs = 1;
            if (line >= VS + VB && line < VS + VB + H && col < 2 * W) begin
                hr  = 1;
                x   = col / 2;
                y   = line - VS - VB;
                rgb = ref_pix((x + sc) % W, y, m_sel);
                px  = (col % 2 == 1) ? int'(rgb[7:0]) : int'(rgb[15:8]);
            end
            if (m_t == FC - 1) dn = 1;
        end
        return (vs << 11) | (hr << 10) | (dn << 9) | (by << 8) | px;
    endfunction

    always @(negedge pclk) begin
        if (cmp_en) chk("stream", dut_vec(), exp_vec());
    end

    // ---------------- helpers ----------------
    task automatic wait_val(input int which, input bit v, input int budget, input string nm);
        int n;
        n = 0;
        while (get_sig(which) != v && n < budget) begin
            @(negedge pclk);
            n++;
        end
        chk(nm, int'(get_sig(which)), int'(v));
    endtask

    task automatic run_len(input int which, input bit v, input int budget, output int n);
        n = 0;
        while (get_sig(which) == v && n < budget) begin
            n++;
            @(negedge pclk);
        end
    endtask

    // Capture the bytes of active line L of the next frame.
    task automatic capture(input int L);
        int  rises, n;
        bit  prev;
        wait_val(S_VSYNC, 1'b1, 2 * FC, "cap_vsync");
        rises = 0; prev = 1'b0; n = 0;
        while (n < 2 * FC) begin
            if (cam.href && !prev) rises++;
            prev = cam.href;
            if (rises == L + 1) break;
            @(negedge pclk);
            n++;
        end
        chk("cap_href_found", rises, L + 1);
        for (int i = 0; i < 2 * W; i++) begin
            line_buf[i] = cam.px_data;
            @(negedge pclk);
        end
    endtask

    initial begin
        #(150000 * 10);
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, pulses;
        bit prev;
        cam.enable      = 1'b0;
        cam.pattern_sel = 2'b00;
        #1 rst = 1'b0;
        #20;
        chk("reset_outputs", dut_vec(), 0);
        @(negedge pclk);
        cmp_en = 1'b1;
        rst    = 1'b1;
        @(negedge pclk);
        chk("idle_outputs", dut_vec(), 0);

        // Frame timing with bars
        cam.enable = 1'b1;
        @(negedge pclk);
        chk("first_vsync", int'(cam.vsync), 1);
        run_len(S_VSYNC, 1'b1, 2 * FC, n); chk("vsync_len", n, 1008);
        run_len(S_HREF, 1'b0, 2 * FC, n);  chk("vsync_to_href", n, 672);
        run_len(S_HREF, 1'b1, 2 * FC, n);  chk("href_high", n, 320);
        run_len(S_HREF, 1'b0, 2 * FC, n);  chk("href_low", n, 16);

        wait_val(S_DONE, 1'b1, 2 * FC, "done_seen");
        @(negedge pclk);
        n = 0; pulses = 0; prev = 1'b0;
        while (!cam.frame_done && n < 2 * FC) begin
            if (cam.href && !prev) pulses++;
            prev = cam.href;
            n++;
            @(negedge pclk);
        end
        chk("frame_period", n + 1, FC);
        chk("href_pulses", pulses, H);

        // Colour bars, first active line
        capture(0);
`ifndef CAM_STREAM_SCROLL_EN
        chk("bars_b0",   line_buf[0],   'hFF);
        chk("bars_b1",   line_buf[1],   'hFF);
        chk("bars_b40",  line_buf[40],  'hFF);
        chk("bars_b41",  line_buf[41],  'hE0);
        chk("bars_b200", line_buf[200], 'hF8);
        chk("bars_b201", line_buf[201], 'h00);
        chk("bars_b318", line_buf[318], 'h00);
        chk("bars_b319", line_buf[319], 'h00);
`endif
        // Select changes mid-frame: current frame keeps bars
        cam.pattern_sel = 2'b11;
        wait_val(S_HREF, 1'b1, 2 * LL, "midframe_href");
`ifndef CAM_STREAM_SCROLL_EN
        chk("midframe_still_bars", int'(cam.px_data), 'hFF);
`endif
        capture(0);
        chk("solid_b0",   line_buf[0],   'hF8);
        chk("solid_b1",   line_buf[1],   'h00);
        chk("solid_b318", line_buf[318], 'hF8);
        chk("solid_b319", line_buf[319], 'h00);

        // Checkerboard
        cam.pattern_sel = 2'b10;
        capture(0);
`ifndef CAM_STREAM_SCROLL_EN
        chk("chk_0_0_hi", line_buf[0],  'h00);
        chk("chk_8_0_hi", line_buf[16], 'hFF);
        chk("chk_8_0_lo", line_buf[17], 'hFF);
`endif
        capture(8);
`ifndef CAM_STREAM_SCROLL_EN
        chk("chk_8_8_hi", line_buf[16], 'h00);
        chk("chk_8_8_lo", line_buf[17], 'h00);
        chk("chk_0_8_hi", line_buf[0],  'hFF);
`endif

        // Random select changes at random points
        repeat (2) begin
            repeat ($urandom_range(1, FC)) @(negedge pclk);
            cam.pattern_sel = 2'($urandom_range(0, 3));
        end

        // Enable dropped mid-frame: frame runs to completion
        wait_val(S_VSYNC, 1'b0, 2 * FC, "drop_wait_low");
        wait_val(S_VSYNC, 1'b1, 2 * FC, "drop_wait_high");
        repeat ((VS + VB + 5) * LL) @(negedge pclk);
        cam.enable = 1'b0;
        n = 0; pulses = 0;
        while (cam.busy && n < 2 * FC) begin
            if (cam.frame_done) pulses++;
            @(negedge pclk);
            n++;
        end
        chk("drop_tail_len", n, FC - (VS + VB + 5) * LL);
        chk("drop_done_pulses", pulses, 1);
        chk("drop_busy_low", int'(cam.busy), 0);
        repeat (20) @(negedge pclk);
        chk("drop_idle_outputs", dut_vec(), 0);

        // Asynchronous reset mid-line
        cam.enable = 1'b1;
        wait_val(S_HREF, 1'b1, 2 * FC, "rst_href_seen");
        repeat (3) @(negedge pclk);
        #2 rst = 1'b0;
        #1 chk("async_rst_outputs", dut_vec(), 0);
        @(negedge pclk);
        @(negedge pclk);
        rst = 1'b1;
        wait_val(S_VSYNC, 1'b1, 4, "rst_vsync_restart");
        run_len(S_VSYNC, 1'b1, 2 * FC, n);
        chk("rst_vsync_len", n, 1008);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
